// File: rtl/cmutex_pkg.sv
// Shared definitions for the N-channel clocked mutual-exclusion merge.
//  - state_e : merge FSM states
//  - CNT_W   : width of the fire-delay counter (FIRE_DELAY up to 15)
//  - ARB_*   : arbitration mode selectors for cmutex_rr_arb
package cmutex_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DRIVE   = 3'd1,
      S_WAIT    = 3'd2,
      S_FIRE    = 3'd3,
      S_BUSY    = 3'd4,
      S_RELEASE = 3'd5
   } state_e;

   localparam int CNT_W     = 4;
   localparam bit ARB_FIXED = 1'b0;
   localparam bit ARB_RR    = 1'b1;

endpackage

// File: rtl/cmutex_merge_n_sync_if.sv
// Handshake bundle between the request channels / next stage and the merge.
//  i_drive     : per-channel one-cycle request pulses
//  i_freeNext  : next stage releases the current grant
//  o_driveNext : grant issued downstream (pulse)
//  o_fire      : delayed fire strobe (pulse)
//  o_data      : one-hot grant vector
//  o_grant_idx : binary index of the grant
//  o_free      : release pulse on the granted channel
//  o_busy      : a grant cycle is in progress
//  o_err       : sticky duplicate-request flag
// master = environment side, slave = merge side.
interface cmutex_merge_n_sync_if #(
   parameter int N_CH = 4
);
   localparam int IDX_W = $clog2(N_CH);

   logic [N_CH-1:0]  i_drive;
   logic             i_freeNext;
   logic             o_driveNext;
   logic             o_fire;
   logic [N_CH-1:0]  o_data;
   logic [IDX_W-1:0] o_grant_idx;
   logic [N_CH-1:0]  o_free;
   logic             o_busy;
   logic             o_err;

   modport master (
      output i_drive, i_freeNext,
      input  o_driveNext, o_fire, o_data, o_grant_idx, o_free, o_busy, o_err
   );

   modport slave (
      input  i_drive, i_freeNext,
      output o_driveNext, o_fire, o_data, o_grant_idx, o_free, o_busy, o_err
   );

endinterface

// File: rtl/cmutex_rr_arb.sv
// Combinational arbiter: picks one requesting channel.
//  req_i   : request vector
//  ptr_i   : round-robin start position
//  mode_i  : ARB_RR = search from ptr_i with wrap, ARB_FIXED = lowest index
//  grant_o : one-hot grant (zero when no request)
//  idx_o   : binary index of grant_o (zero when no request)
module cmutex_rr_arb
   import cmutex_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int IDX_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic             mode_i,
   output logic [N_CH-1:0]  grant_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N_CH; k++) begin
         // Candidate k steps away from the start position; fixed mode starts at 0.
         cand = (mode_i == ARB_RR) ? IDX_W'((int'(ptr_i) + k) % N_CH) : IDX_W'(k);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/cmutex_merge_n_sync.sv
// N-channel clocked mutual-exclusion merge.
// Captures per-channel drive pulses into a pending vector, grants one channel
// at a time, pulses o_driveNext, then o_fire FIRE_DELAY cycles later, holds
// the one-hot grant until i_freeNext is seen in BUSY and returns o_free to the
// granted channel. Duplicate requests raise a sticky o_err.
//  clk : rising-edge clock
//  rst : asynchronous active-low reset
//  bus : handshake bundle (slave side)
module cmutex_merge_n_sync
   import cmutex_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int FIRE_DELAY = 2,
   parameter int RR_MODE    = 1
) (
   input logic                  clk,
   input logic                  rst,
   cmutex_merge_n_sync_if.slave bus
);

   localparam int               IDX_W     = $clog2(N_CH);
   localparam bit               ARB_MODE  = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;
   // WAIT lasts FIRE_DELAY-1 cycles: counter runs 0 .. FIRE_DELAY-2.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((FIRE_DELAY >= 2) ? FIRE_DELAY - 2 : 0);

   state_e           state_q, state_d;
   logic [N_CH-1:0]  pending_q, pending_d;
   logic [N_CH-1:0]  data_q, data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [N_CH-1:0]  rel_mask;
   logic [N_CH-1:0]  busy_mask;
   logic [N_CH-1:0]  arb_req;
   logic [N_CH-1:0]  arb_grant;
   logic [IDX_W-1:0] arb_idx;

   logic             drive_next;
   logic             fire;
   logic             busy;
   logic [N_CH-1:0]  free;

   cmutex_rr_arb #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
      .req_i   (arb_req),
      .ptr_i   (ptr_q),
      .mode_i  (ARB_MODE),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         data_q    <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      // The channel being released may re-request in the same cycle.
      rel_mask  = (state_q == S_RELEASE) ? data_q : '0;
      busy_mask = (pending_q | data_q) & ~rel_mask;
      pending_d = (pending_q & ~rel_mask) | (bus.i_drive & ~busy_mask);
      err_d     = err_q | (|(bus.i_drive & busy_mask));
      // The granted channel stays pending until release; keep it out of arbitration.
      arb_req   = pending_q & ~data_q;

      case (state_q)
         S_IDLE, S_RELEASE: begin
            if (|arb_req) begin
               state_d = S_DRIVE;
               data_d  = arb_grant;
               idx_d   = arb_idx;
               if (ARB_MODE == ARB_RR) begin
                  ptr_d = IDX_W'((int'(arb_idx) + 1) % N_CH);
               end
            end else begin
               state_d = S_IDLE;
               data_d  = '0;
               idx_d   = '0;
            end
         end
         S_DRIVE: begin
            if (FIRE_DELAY == 1) begin
               state_d = S_FIRE;
            end else begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = S_FIRE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIRE: state_d = S_BUSY;
         S_BUSY: begin
            if (bus.i_freeNext) begin
               state_d = S_RELEASE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      drive_next = (state_q == S_DRIVE);
      fire       = (state_q == S_FIRE);
      busy       = (state_q != S_IDLE);
      free       = (state_q == S_RELEASE) ? data_q : '0;
   end

   assign bus.o_driveNext = drive_next;
   assign bus.o_fire      = fire;
   assign bus.o_busy      = busy;
   assign bus.o_free      = free;
   assign bus.o_data      = data_q;
   assign bus.o_grant_idx = idx_q;
   assign bus.o_err       = err_q;

endmodule

// File: tb/tb_cmutex_merge_n_sync.sv
// Directed bench for cmutex_merge_n_sync: two instances (round-robin and
// fixed priority) receive identical stimulus; each scenario task checks its
// own hand-computed expectations.
module tb_cmutex_merge_n_sync;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   cmutex_merge_n_sync_if #(.N_CH(4)) ifa ();
   cmutex_merge_n_sync_if #(.N_CH(4)) ifb ();

   cmutex_merge_n_sync #(.N_CH(4), .FIRE_DELAY(2), .RR_MODE(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   cmutex_merge_n_sync #(.N_CH(4), .FIRE_DELAY(2), .RR_MODE(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic [3:0] d, input logic f);
      ifa.i_drive    = d;
      ifa.i_freeNext = f;
      ifb.i_drive    = d;
      ifb.i_freeNext = f;
   endtask

   // Leaves both DUTs idle; the caller's cycle 0 starts at return.
   task automatic do_reset();
      drive_in(4'b0000, 1'b0);
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [13:0] got;
      drive_in(4'b1111, 1'b1);
      rst = 1'b0;
      step();
      got = {ifa.o_driveNext, ifa.o_fire, ifa.o_busy, ifa.o_err, ifa.o_data, ifa.o_free, ifa.o_grant_idx};
      n_assert++;
      if (got !== 14'h0) begin n_fail++; $display("FAIL reset_a outputs got=%h exp=0", got); end
      got = {ifb.o_driveNext, ifb.o_fire, ifb.o_busy, ifb.o_err, ifb.o_data, ifb.o_free, ifb.o_grant_idx};
      n_assert++;
      if (got !== 14'h0) begin n_fail++; $display("FAIL reset_b outputs got=%h exp=0", got); end
      do_reset();
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic       e_drv  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       e_fire [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       e_busy [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0] e_data [9] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
      logic [3:0] e_free [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
      logic [1:0] e_idx  [9] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      logic [12:0] got, exp;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         drive_in((c == 0) ? 4'b0100 : 4'b0000, (c == 6));
         got = {ifa.o_driveNext, ifa.o_fire, ifa.o_busy, ifa.o_data, ifa.o_free, ifa.o_grant_idx};
         exp = {e_drv[c], e_fire[c], e_busy[c], e_data[c], e_free[c], e_idx[c]};
         n_assert++;
         if (got !== exp) begin n_fail++; $display("FAIL single_c%0d {drv,fire,busy,data,free,idx} got=%h exp=%h", c, got, exp); end
         step();
      end
      $display("test_single done");
   endtask

   task automatic test_simultaneous();
      logic       e_drv  [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       e_busy [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0] e_data [13] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
      logic [3:0] e_free [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
      logic [9:0] got, exp;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         drive_in((c == 0) ? 4'b1001 : 4'b0000, 1'b1);
         exp = {e_drv[c], e_busy[c], e_data[c], e_free[c]};
         got = {ifa.o_driveNext, ifa.o_busy, ifa.o_data, ifa.o_free};
         n_assert++;
         if (got !== exp) begin n_fail++; $display("FAIL simul_a_c%0d {drv,busy,data,free} got=%h exp=%h", c, got, exp); end
         got = {ifb.o_driveNext, ifb.o_busy, ifb.o_data, ifb.o_free};
         n_assert++;
         if (got !== exp) begin n_fail++; $display("FAIL simul_b_c%0d {drv,busy,data,free} got=%h exp=%h", c, got, exp); end
         step();
      end
      $display("test_simultaneous done");
   endtask

   task automatic test_fairness();
      logic [3:0] d;
      logic       e_drv;
      logic [1:0] e_idx;
      do_reset();
      for (int c = 0; c < 23; c++) begin
         d = (c == 0) ? 4'b0011 : (c == 6) ? 4'b0001 : (c == 11) ? 4'b0010 : 4'b0000;
         drive_in(d, 1'b1);
         e_drv = (c == 2 || c == 7 || c == 12 || c == 17);
         n_assert++;
         if (ifa.o_driveNext !== e_drv) begin n_fail++; $display("FAIL fair_a_drv_c%0d got=%b exp=%b", c, ifa.o_driveNext, e_drv); end
         n_assert++;
         if (ifb.o_driveNext !== e_drv) begin n_fail++; $display("FAIL fair_b_drv_c%0d got=%b exp=%b", c, ifb.o_driveNext, e_drv); end
         if (e_drv) begin
            e_idx = 2'(((c - 2) / 5) % 2);
            n_assert++;
            if (ifa.o_grant_idx !== e_idx) begin n_fail++; $display("FAIL fair_a_idx_c%0d got=%0d exp=%0d", c, ifa.o_grant_idx, e_idx); end
            n_assert++;
            if (ifb.o_grant_idx !== e_idx) begin n_fail++; $display("FAIL fair_b_idx_c%0d got=%0d exp=%0d", c, ifb.o_grant_idx, e_idx); end
         end
         if (c == 22) begin
            n_assert++;
            if ({ifa.o_busy, ifa.o_err, ifb.o_busy, ifb.o_err} !== 4'b0000) begin
               n_fail++; $display("FAIL fair_end {busyA,errA,busyB,errB} got=%b exp=0000", {ifa.o_busy, ifa.o_err, ifb.o_busy, ifb.o_err});
            end
         end
         step();
      end
      $display("test_fairness done");
   endtask

   // Pending {0,2} after ch1 release: round-robin (pointer at 2) takes ch2, fixed takes ch0.
   task automatic test_fixed_priority();
      logic [1:0] a_idx [3] = '{2'd1, 2'd2, 2'd0};
      logic [1:0] b_idx [3] = '{2'd1, 2'd0, 2'd2};
      logic [6:0] got, exp;
      int k;
      do_reset();
      for (int c = 0; c < 18; c++) begin
         drive_in((c == 0) ? 4'b0110 : (c == 3) ? 4'b0001 : 4'b0000, 1'b1);
         if (c == 2 || c == 7 || c == 12) begin
            k = (c - 2) / 5;
            got = {ifa.o_driveNext, ifa.o_data, ifa.o_grant_idx};
            exp = {1'b1, 4'(1 << a_idx[k]), a_idx[k]};
            n_assert++;
            if (got !== exp) begin n_fail++; $display("FAIL prio_rr_c%0d {drv,data,idx} got=%h exp=%h", c, got, exp); end
            got = {ifb.o_driveNext, ifb.o_data, ifb.o_grant_idx};
            exp = {1'b1, 4'(1 << b_idx[k]), b_idx[k]};
            n_assert++;
            if (got !== exp) begin n_fail++; $display("FAIL prio_fix_c%0d {drv,data,idx} got=%h exp=%h", c, got, exp); end
         end
         if (c == 17) begin
            n_assert++;
            if ({ifa.o_busy, ifa.o_err, ifb.o_busy, ifb.o_err} !== 4'b0000) begin
               n_fail++; $display("FAIL prio_end {busyA,errA,busyB,errB} got=%b exp=0000", {ifa.o_busy, ifa.o_err, ifb.o_busy, ifb.o_err});
            end
         end
         step();
      end
      $display("test_fixed_priority done");
   endtask

   task automatic test_error();
      int n_free;
      n_free = 0;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         drive_in((c == 0 || c == 3) ? 4'b0010 : 4'b0000, (c == 6));
         n_assert++;
         if (ifa.o_err !== (c >= 4)) begin n_fail++; $display("FAIL err_c%0d got=%b exp=%b", c, ifa.o_err, (c >= 4)); end
         if (ifa.o_free != 4'b0000) n_free++;
         if (c == 7) begin
            n_assert++;
            if (ifa.o_free !== 4'b0010) begin n_fail++; $display("FAIL err_free_c7 got=%b exp=0010", ifa.o_free); end
         end
         step();
      end
      n_assert++;
      if (n_free != 1) begin n_fail++; $display("FAIL err_free_count got=%0d exp=1", n_free); end
      n_assert++;
      if (ifa.o_busy !== 1'b0) begin n_fail++; $display("FAIL err_idle got=%b exp=0", ifa.o_busy); end
      $display("test_error done");
   endtask

   task automatic test_reset_busy();
      logic [13:0] got;
      logic [8:0]  got2;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive_in((c == 0) ? 4'b1000 : 4'b0000, 1'b0);
         step();
      end
      n_assert++;
      if ({ifa.o_busy, ifa.o_data} !== 5'b1_1000) begin n_fail++; $display("FAIL rstbusy_pre {busy,data} got=%b exp=11000", {ifa.o_busy, ifa.o_data}); end
      rst = 1'b0;
      #1;
      got = {ifa.o_driveNext, ifa.o_fire, ifa.o_busy, ifa.o_err, ifa.o_data, ifa.o_free, ifa.o_grant_idx};
      n_assert++;
      if (got !== 14'h0) begin n_fail++; $display("FAIL rstbusy_a outputs got=%h exp=0", got); end
      got = {ifb.o_driveNext, ifb.o_fire, ifb.o_busy, ifb.o_err, ifb.o_data, ifb.o_free, ifb.o_grant_idx};
      n_assert++;
      if (got !== 14'h0) begin n_fail++; $display("FAIL rstbusy_b outputs got=%h exp=0", got); end
      step();
      step();
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         got2 = {ifa.o_busy, ifa.o_data, ifa.o_free};
         n_assert++;
         if (got2 !== 9'h0) begin n_fail++; $display("FAIL rstbusy_idle_c%0d {busy,data,free} got=%h exp=0", c, got2); end
         step();
      end
      $display("test_reset_busy done");
   endtask

   task automatic test_early_free();
      logic [8:0] got, exp;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         drive_in((c == 0) ? 4'b0001 : 4'b0000, (c == 2 || c == 3 || c == 9));
         exp = {(c >= 2 && c <= 10), ((c >= 2 && c <= 10) ? 4'b0001 : 4'b0000), ((c == 10) ? 4'b0001 : 4'b0000)};
         got = {ifa.o_busy, ifa.o_data, ifa.o_free};
         n_assert++;
         if (got !== exp) begin n_fail++; $display("FAIL early_c%0d {busy,data,free} got=%h exp=%h", c, got, exp); end
         step();
      end
      $display("test_early_free done");
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b0;
      drive_in(4'b0000, 1'b0);
      step();
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_fixed_priority();
      test_error();
      test_reset_busy();
      test_early_free();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
